// File: rtl/bk_pipe_adder.sv
// Three-stage pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// S1 forms bitwise generate/propagate, S2 runs the up-sweep, S3 the down-sweep, sum and flags.
module bk_pipe_adder #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int LG = $clog2(N);

  logic         e1_s, e2_s, e3_s;
  logic         v1_r, v2_r, v3_r;
  logic [N-1:0] be_s;
  logic [N-1:0] g1_r, p1_r;
  logic         cin1_r;
  logic [N-1:0] gu_s, pu_s;
  logic [N-1:0] gu_r, pu_r, p2_r;
  logic         cin2_r;
  logic [N-1:0] gp_s, pp_s;
  logic [N:0]   c_s;
  logic [N-1:0] sum_s;
  logic [N-1:0] sum_r;
  logic         cout_r, ovf_r, zero_r;

  // Stage enables ripple back from the consumer so an empty stage always loads.
  always_comb begin
    e3_s = ~v3_r | out_ready;
    e2_s = ~v2_r | e3_s;
    e1_s = ~v1_r | e2_s;
  end

  assign in_ready = e1_s;
  assign be_s     = b ^ {N{op}};

  // S1: bitwise generate/propagate of a and the (optionally inverted) b.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      g1_r   <= {N{1'b0}};
      p1_r   <= {N{1'b0}};
      cin1_r <= 1'b0;
    end else if (e1_s) begin
      v1_r   <= in_valid;
      g1_r   <= a & be_s;
      p1_r   <= a ^ be_s;
      cin1_r <= cin;
    end
  end

  // Up-sweep: at level l, node i (i+1 a multiple of 2^l) absorbs the group ending 2^(l-1) below.
  always_comb begin
    gu_s = g1_r;
    pu_s = p1_r;
    for (int l = 32'sd1; l <= LG; l++) begin
      for (int i = (32'sd1 <<< l) - 32'sd1; i < N; i += (32'sd1 <<< l)) begin
        gu_s[i] = gu_s[i] | (pu_s[i] & gu_s[i - (32'sd1 <<< (l - 32'sd1))]);
        pu_s[i] = pu_s[i] & pu_s[i - (32'sd1 <<< (l - 32'sd1))];
      end
    end
  end

  // S2: up-sweep tree nodes plus the bit propagates needed for the final sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r   <= 1'b0;
      gu_r   <= {N{1'b0}};
      pu_r   <= {N{1'b0}};
      p2_r   <= {N{1'b0}};
      cin2_r <= 1'b0;
    end else if (e2_s) begin
      v2_r   <= v1_r;
      gu_r   <= gu_s;
      pu_r   <= pu_s;
      p2_r   <= p1_r;
      cin2_r <= cin1_r;
    end
  end

  // Down-sweep grey cells fill in the remaining prefixes, then carries fold in cin.
  always_comb begin
    gp_s = gu_r;
    pp_s = pu_r;
    for (int l = LG - 32'sd1; l >= 32'sd1; l--) begin
      for (int i = 32'sd3 * (32'sd1 <<< (l - 32'sd1)) - 32'sd1; i < N; i += (32'sd1 <<< l)) begin
        gp_s[i] = gp_s[i] | (pp_s[i] & gp_s[i - (32'sd1 <<< (l - 32'sd1))]);
        pp_s[i] = pp_s[i] & pp_s[i - (32'sd1 <<< (l - 32'sd1))];
      end
    end
    c_s    = {(N + 1){1'b0}};
    c_s[0] = cin2_r;
    for (int i = 32'sd0; i < N; i++) begin
      c_s[i + 1] = gp_s[i] | (pp_s[i] & cin2_r);
    end
    sum_s = p2_r ^ c_s[N-1:0];
  end

  // S3: result and flags; these registers drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r   <= 1'b0;
      sum_r  <= {N{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (e3_s) begin
      v3_r   <= v2_r;
      sum_r  <= sum_s;
      cout_r <= c_s[N];
      ovf_r  <= c_s[N] ^ c_s[N-1];
      zero_r <= ~|sum_s;
    end
  end

  assign out_valid = v3_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: doc/bk_pipe_adder.md
Name: bk_pipe_adder

Overview:
- Parametrised, 3-stage pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready flow control on both sides.
- Successor to the fixed-width combinational 64-bit prefix adder: width is generic, add/subtract is selected per transaction, and signed-overflow and zero flags are produced.
- Sits between operand-issue logic and a result consumer that may apply backpressure.

Parameters:
- N, 64, operand width; power of two, 4..128; the prefix tree has log2(N) up-sweep and log2(N)-1 down-sweep levels.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- cin  in  1  carry-in (borrow-not for subtract).
- op  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  N  result.
- cout  out  1  carry out of bit N-1.
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Arithmetic:
  - op=0: {cout,sum} = a + b + cin.
  - op=1: {cout,sum} = a + ~b + cin. cin=1 gives a-b; cin=0 gives a-b-1. cout=1 means no borrow.
  - ovf = c[N] ^ c[N-1], where c[k] is the carry into bit k.
  - zero = ~|sum.
  - All results are taken modulo 2^N.
- Stage S1 (register on accept):
  - be = b ^ {N{op}}.
  - g = a & be, p = a ^ be.
  - Registers g, p, cin, and a valid bit v1.
- Stage S2:
  - Brent-Kung up-sweep (black cells at levels 1..log2(N)) on the S1 registers.
  - Registers the group-G/P tree nodes, the bit p, cin, and v2.
- Stage S3:
  - Down-sweep (grey cells) produces prefix G[0..i].
  - c[i+1] = G[0..i] | (P[0..i] & cin).
  - sum = p ^ c[N-1:0].
  - Flags are computed here; registers sum, cout, ovf, zero, and v3.
- Outputs are driven directly from the S3 registers. out_valid = v3.
- Latency: exactly 3 cycles from the accepting edge to out_valid high when there is no stall. Throughput is 1 beat per cycle.
- Flow control, evaluated each cycle:
  - e3 = ~v3 | out_ready
  - e2 = ~v2 | e3
  - e1 = ~v1 | e2
  - in_ready = e1
  - Stage k loads when ek. Its valid bit becomes the upstream valid: in_valid for S1, v1 for S2, v2 for S3.
  - A stage that is not enabled holds its data and valid bit.
  - Bubbles collapse: an empty stage loads even while downstream is stalled.
- Handshake rules:
  - A beat transfers on in_valid & in_ready.
  - A result retires on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, sum, cout, ovf and zero stay stable.
  - in_ready depends combinationally on out_ready. No combinational path exists from in_valid to in_ready.
- Full pipeline:
  - With v1=v2=v3=1 and out_ready=0, in_ready=0.
  - With out_ready=1 in the same state, all stages advance and a new beat is accepted in the same cycle.
- Reset:
  - Asserting rst_n low at any time clears v1, v2, v3 immediately.
  - On reset, out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - Internal data registers may also clear to 0.
  - In-flight beats are discarded.
  - in_ready=1 while in reset and after release.
- Data registers are don't-care while their valid bit is low. Outputs are checked only when out_valid=1.

Test Plan:
- N=64, op=0, a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1, out_ready=1 -> 3 cycles later sum=0, cout=1, zero=1, ovf=0.
- N=8, op=0, a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1, zero=0. Then op=1, a=0x80, b=0x01, cin=1 -> sum=0x7F, cout=1, ovf=1.
- N=8, op=1, a=0x05, b=0x05, cin=1 -> sum=0x00, cout=1, zero=1. Same operands with cin=0 -> sum=0xFF, cout=0, zero=0.
- Backpressure: stream 6 beats back-to-back, hold out_ready=0 from cycle 4 to cycle 9 -> in_ready drops after 3 beats are in flight, sum/flags stay stable while stalled, and all 6 results emerge in order with none lost or duplicated.
- Random: 10k beats per N in {4, 8, 32, 64, 128}, random op/cin/in_valid/out_ready -> every result matches the reference model (a ± b + cin) and flags, in order.
- Reset mid-stream: pulse rst_n low asynchronously (between edges) while 3 beats are in flight -> out_valid drops immediately, no stale beats emerge, and the first post-reset beat appears 3 cycles after acceptance.
